// File: rtl/button_conditioner.sv
// Push-button front end: per-button 2-flop synchroniser, debounce FSM, clean level
// and one-cycle press pulse. Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat pulses.
module button_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int HOLD_CYCLES     = 62500000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic               CLOCK,
    input  logic               RES,
    input  logic [NUM_BTN-1:0] BUTTONS_RAW,
    output logic [NUM_BTN-1:0] BUTTONS_LEVEL,
    output logic [NUM_BTN-1:0] BUTTONS_PULSE
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("button_conditioner: cycle parameters must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [1:0]    sync_q, sync_d;
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          pulse_q, pulse_d;
        logic          s;
`ifdef BUTTON_AUTOREPEAT_EN
        logic [RW-1:0] rc_q, rc_d;
        logic          rep_q, rep_d;   // 0: waiting for first repeat, 1: periodic repeats
`endif

        assign s = sync_q[1];

        always_ff @(posedge CLOCK) begin
            if (RES) begin
                sync_q  <= '0;
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                rc_q    <= '0;
                rep_q   <= 1'b0;
`endif
            end else begin
                sync_q  <= sync_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
`ifdef BUTTON_AUTOREPEAT_EN
                rc_q    <= rc_d;
                rep_q   <= rep_d;
`endif
            end
        end

        always_comb begin
            sync_d  = {sync_q[0], BUTTONS_RAW[i]};
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            rc_d    = rc_q;
            rep_d   = rep_q;
`endif
            unique case (state_q)
                IDLE: begin
                    level_d = 1'b0;
                    if (s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        rc_d    = '0;
                        rep_d   = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    level_d = 1'b1;
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
`ifdef BUTTON_AUTOREPEAT_EN
                        rc_d    = '0;
                        rep_d   = 1'b0;
                    end else if (rc_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
                        pulse_d = 1'b1;
                        rc_d    = '0;
                        rep_d   = 1'b1;
                    end else begin
                        rc_d = rc_q + 1'b1;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        // bounce while releasing: back to held, no fresh press pulse
                        state_d = PRESSED;
`ifdef BUTTON_AUTOREPEAT_EN
                        rc_d    = '0;
                        rep_d   = 1'b0;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign BUTTONS_LEVEL[i] = level_q;
        assign BUTTONS_PULSE[i] = pulse_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner: a run-length debounce model predicts
// level/pulse every cycle into a queue; a negedge monitor pops and compares.
module tb_button_conditioner;
    localparam int NB = 2;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 3;

    logic          clk = 1'b0;
    logic          res;
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pls;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut (
        .CLOCK(clk), .RES(res), .BUTTONS_RAW(raw),
        .BUTTONS_LEVEL(lvl), .BUTTONS_PULSE(pls)
    );

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [2*NB-1:0] exp_q[$];

    // Model: raw reaches the debouncer two edges late; the level flips once the
    // synchronised input has disagreed with it for D+1 consecutive edges.
    logic [NB-1:0] r1, r2, mlev;
    int run[NB];
    int held[NB];

    always @(posedge clk) begin : model
        logic [NB-1:0] s, pl;
        pl = '0;
        if (res) begin
            r1 = '0; r2 = '0; mlev = '0;
            for (int b = 0; b < NB; b++) begin run[b] = 0; held[b] = 0; end
        end else begin
            s  = r2;
            r2 = r1;
            r1 = raw;
            for (int b = 0; b < NB; b++) begin
                if (!mlev[b]) begin
                    if (s[b]) begin
                        run[b]++;
                        if (run[b] == D + 1) begin
                            mlev[b] = 1'b1; pl[b] = 1'b1; run[b] = 0; held[b] = 0;
                        end
                    end else run[b] = 0;
                end else begin
                    if (!s[b]) begin
                        run[b]++;
                        if (run[b] == D + 1) begin mlev[b] = 1'b0; run[b] = 0; end
                    end else if (run[b] > 0) begin
                        run[b] = 0; held[b] = 0;
                    end else begin
                        held[b]++;
`ifdef BUTTON_AUTOREPEAT_EN
                        if (held[b] == H || (held[b] > H && (held[b] - H) % R == 0))
                            pl[b] = 1'b1;
`endif
                    end
                end
            end
        end
        exp_q.push_back({mlev, pl});
    end

    always @(negedge clk) begin : monitor
        logic [2*NB-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            checks++;
            if ({lvl, pls} !== e) begin
                failures++;
                $display("FAIL outputs t=%0t level=%b pulse=%b expected level=%b pulse=%b",
                         $time, lvl, pls, e[2*NB-1:NB], e[NB-1:0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        res = 1'b1;
        raw = '0;
        cyc(3);
        res = 1'b0;
        // single press on button 0, then release
        raw = 2'b01; cyc(20);
        raw = 2'b00; cyc(12);
        // fast bounce never qualifies
        raw = 2'b01; cyc(1); raw = 2'b00; cyc(1);
        raw = 2'b01; cyc(1); raw = 2'b00; cyc(10);
        // short release glitch while held
        raw = 2'b01; cyc(12);
        raw = 2'b00; cyc(2);
        raw = 2'b01; cyc(6);
        raw = 2'b00; cyc(12);
        // simultaneous presses
        raw = 2'b11; cyc(12);
        raw = 2'b00; cyc(12);
        // reset in the middle of qualification
        raw = 2'b01; cyc(4);
        res = 1'b1; cyc(1);
        res = 1'b0; raw = 2'b00; cyc(10);
        // button held across reset release
        raw = 2'b10; res = 1'b1; cyc(2);
        res = 1'b0; cyc(15);
        raw = 2'b00; cyc(10);
        // long hold on button 1 (auto-repeat when enabled)
        raw = 2'b10; cyc(30);
        raw = 2'b00; cyc(15);
        // random segments with bounce and occasional reset
        for (int k = 0; k < 500; k++) begin
            raw = NB'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) res = 1'b1;
            cyc(1);
            res = 1'b0;
            cyc($urandom_range(0, 13));
        end
        raw = '0;
        cyc(12);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end
        checks++;
        if (pops < 100) begin
            failures++;
            $display("FAIL monitor_activity pops=%0d required>=100", pops);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
